// File: rtl/dmg_fb_arbiter.sv
`timescale 1ns/1ps
// Frame-buffer SRAM arbiter: LCD byte prefetch with absolute priority, host port in spare slots.
// Optional host reads (host_we/host_rdata) are enabled by defining FB_HOST_READ_EN.
module dmg_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 160,
  parameter int ADDR_W = 13
) (
  input  logic              clk_8m,
  input  logic              rst,
  input  logic [8:0]        xpos_in,
  input  logic [7:0]        ypos_in,
  output logic [1:0]        pix_out,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
`ifdef FB_HOST_READ_EN
  input  logic              host_we,
  output logic [7:0]        host_rdata,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam int LINE_BYTES = FB_W / 4;
  localparam int FB_BYTES   = FB_H * LINE_BYTES;

  localparam logic [8:0] X_ACT  = 9'(FB_W);
  localparam logic [8:0] X_LAST = 9'(FB_W - 4);
  localparam logic [8:0] X_PRE  = 9'd508;
  localparam logic [7:0] Y_ACT  = 8'(FB_H);
  localparam logic [ADDR_W-1:0] A_END = ADDR_W'(FB_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_HWR,
    S_HRD
  } st_e;

  st_e               st_q;
  logic [8:0]        xpos_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q;
  logic              ack_q;
  logic              cap_q;
  logic [7:0]        pre_q;
  logic [7:0]        cur_q;
  logic [1:0]        pix_q;

  logic              y_act;
  logic              new_x;
  logic              grp_first;
  logic              grp_next;
  logic              trig;
  logic              load;
  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] fetch_addr;
  logic [7:0]        cur_d;
  logic [1:0]        pix_sel;
  logic [1:0]        pix_d;
  logic              host_oor;
  logic              host_busy;
  logic              host_go;

  // Deliberately not reset: it tracks xpos_in through reset so a
  // static position after release is never mistaken for a new pixel.
  always_ff @(posedge clk_8m) begin
    xpos_q <= xpos_in;
  end

  assign y_act     = ypos_in < Y_ACT;
  assign new_x     = (xpos_in != xpos_q) && y_act;
  assign grp_first = xpos_in == X_PRE;
  assign grp_next  = (xpos_in[1:0] == 2'b00)
                  && (xpos_in < X_LAST);
  assign trig      = new_x && (grp_first || grp_next);
  assign load      = new_x && (xpos_in[1:0] == 2'b00)
                  && (xpos_in < X_ACT);

  assign grp = grp_first ? '0
             : ADDR_W'(xpos_in[8:2]) + ADDR_W'(1);
  assign fetch_addr = ADDR_W'(ypos_in) * ADDR_W'(LINE_BYTES)
                    + grp;

  assign cur_d = load ? pre_q : cur_q;

  always_comb begin
    pix_sel = 2'b00;
    unique case (xpos_in[1:0])
      2'd0: pix_sel = cur_d[7:6];
      2'd1: pix_sel = cur_d[5:4];
      2'd2: pix_sel = cur_d[3:2];
      2'd3: pix_sel = cur_d[1:0];
    endcase
  end

  assign pix_d = ((xpos_in < X_ACT) && y_act) ? pix_sel : 2'b00;

  assign host_oor = host_addr >= A_END;
`ifdef FB_HOST_READ_EN
  logic oor_q;
  assign host_busy = ack_q || (st_q == S_HRD);
`else
  assign host_busy = ack_q;
`endif
  assign host_go = host_req && !host_busy;

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      st_q        <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      ack_q       <= 1'b0;
`ifdef FB_HOST_READ_EN
      oor_q       <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      ack_q    <= 1'b0;
      if (trig) begin
        st_q       <= S_DISP;
        mem_addr_q <= fetch_addr;
      end
`ifdef FB_HOST_READ_EN
      else if (host_go && !host_we) begin
        st_q  <= S_HRD;
        oor_q <= host_oor;
        if (!host_oor) mem_addr_q <= host_addr;
      end
`endif
      else if (host_go) begin
        st_q        <= S_HWR;
        ack_q       <= 1'b1;
        mem_we_q    <= !host_oor;
        mem_wdata_q <= host_wdata;
        if (!host_oor) mem_addr_q <= host_addr;
      end else begin
        st_q <= S_IDLE;
      end
`ifdef FB_HOST_READ_EN
      if (st_q == S_HRD) ack_q <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      cap_q <= 1'b0;
      pre_q <= '0;
      cur_q <= '0;
      pix_q <= '0;
    end else begin
      cap_q <= st_q == S_DISP;
      if (cap_q) pre_q <= mem_rdata;
      cur_q <= cur_d;
      pix_q <= pix_d;
    end
  end

`ifdef FB_HOST_READ_EN
  logic       rack_q;
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  assign rdata_d = oor_q ? 8'h00 : mem_rdata;

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      rack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rack_q <= st_q == S_HRD;
      if (rack_q) rdata_q <= rdata_d;
    end
  end

  assign host_rdata = rack_q ? rdata_d : rdata_q;
`endif

  assign pix_out   = pix_q;
  assign host_ack  = ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_dmg_fb_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for dmg_fb_arbiter: directed sweeps and host transfers against an SRAM model.
// Build with +define+FB_HOST_READ_EN to also exercise host reads.
module tb_dmg_fb_arbiter;

  logic        clk_8m = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  xpos_in = '0;
  logic [7:0]  ypos_in = '0;
  logic [1:0]  pix_out;
  logic        host_req = 1'b0;
  logic [12:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
`ifdef FB_HOST_READ_EN
  logic        host_we = 1'b1;
  logic [7:0]  host_rdata;
`endif
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;

  dmg_fb_arbiter dut (
    .clk_8m     (clk_8m),
    .rst        (rst),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .pix_out    (pix_out),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
`ifdef FB_HOST_READ_EN
    .host_we    (host_we),
    .host_rdata (host_rdata),
`endif
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk_8m = ~clk_8m;

  logic [7:0] sram [8192];

  function automatic logic [7:0] init_byte(int a);
    if (a < 40) return (a % 2 == 0) ? 8'h1B : 8'hE4;
    return 8'(a) ^ 8'h5A;
  endfunction

  always @(posedge clk_8m) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  data;
  } mev_t;

  typedef struct packed {
    logic [3:0] lat;
    logic       we;
    logic [7:0] rd;
  } ack_t;

  mev_t       mem_q[$];
  ack_t       ack_q[$];
  logic [1:0] pix_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_mem(logic we, int a, int d);
    mev_t e;
    e.we = we;
    e.addr = 13'(a);
    e.data = 8'(d);
    mem_q.push_back(e);
  endtask

  task automatic push_ack(int lat, logic we, int rd);
    ack_t e;
    e.lat = 4'(lat);
    e.we = we;
    e.rd = 8'(rd);
    ack_q.push_back(e);
  endtask

  // Monitor: every visible SRAM access, ack and settled pixel is popped here
  logic [12:0] prev_addr = '0;
  logic [8:0]  x_last = '0;
  int          x_age = 0;
  int          req_age = 0;

  always @(negedge clk_8m) begin
    mev_t e;
    ack_t a;
    if (rst) begin
      prev_addr = mem_addr;
      req_age = 0;
    end else begin
      if (mem_we || mem_addr != prev_addr) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem: we=%0b addr=%0h, expected no access",
                   mem_we, mem_addr);
        end else begin
          e = mem_q.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
        prev_addr = mem_addr;
      end
      if (host_ack) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: host_ack=1, expected 0");
        end else begin
          a = ack_q.pop_front();
          chk("ack_latency", req_age, a.lat);
          chk("ack_mem_we", mem_we, a.we);
`ifdef FB_HOST_READ_EN
          chk("host_rdata", host_rdata, a.rd);
`endif
        end
        req_age = 0;
      end else if (host_req) begin
        req_age++;
      end
      if (xpos_in != x_last) begin
        x_last = xpos_in;
        x_age = 0;
      end else begin
        x_age++;
      end
      if (x_age == 1 && pix_q.size() > 0)
        chk($sformatf("pix_x%0d", xpos_in), pix_out, pix_q.pop_front());
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_8m);
    #1;
  endtask

  task automatic host_xfer(int a, int d, logic we, int lat, int rd, logic keep);
    bit got = 0;
    logic inr = a < 6400;
    push_ack(lat, we && inr, rd);
    if (we && inr) push_mem(1'b1, a, d);
    host_addr = 13'(a);
    host_wdata = 8'(d);
`ifdef FB_HOST_READ_EN
    host_we = we;
`endif
    host_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_8m);
      if (host_ack) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: addr=%0h no host_ack in 20 clks", a);
    end
    @(posedge clk_8m);
    #1;
    if (!keep) host_req = 1'b0;
  endtask

  task automatic sweep(int y);
    int x;
    int pix;
    logic [7:0] b;
    ypos_in = 8'(y);
    for (int i = 0; i < 580; i++) begin
      x = (i < 80) ? 432 + i : i - 80;
      xpos_in = 9'(x);
      pix = 0;
      if (y < 160) begin
        if (x == 508) push_mem(1'b0, y * 40, 0);
        else if (x % 4 == 0 && x < 156) push_mem(1'b0, y * 40 + x / 4 + 1, 0);
        if (x < 160) begin
          b = init_byte(y * 40 + x / 4);
          pix = (b >> (6 - 2 * (x % 4))) & 3;
        end
      end
      pix_q.push_back(2'(pix));
      tick(2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 8192; a++) sram[a] = init_byte(a);

    // reset with random inputs, then release with x static
    for (int i = 0; i < 4; i++) begin
      xpos_in = 9'($urandom);
      ypos_in = 8'($urandom);
      host_req = 1'($urandom);
      host_addr = 13'($urandom);
      host_wdata = 8'($urandom);
      @(negedge clk_8m);
      chk("rst_pix_out", pix_out, 0);
      chk("rst_host_ack", host_ack, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", mem_we, 0);
`ifdef FB_HOST_READ_EN
      chk("rst_host_rdata", host_rdata, 0);
`endif
      @(posedge clk_8m);
      #1;
    end
    xpos_in = 9'd8;
    ypos_in = 8'd0;
    host_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(12);
    chk("idle_mem_addr", mem_addr, 0);

    // idle host write, then two back-to-back writes with req held
    host_xfer(13'h0100, 8'hA5, 1'b1, 1, 0, 1'b0);
    tick(2);
    host_xfer(13'h0200, 8'h11, 1'b1, 1, 0, 1'b1);
    host_xfer(13'h0201, 8'h22, 1'b1, 1, 0, 1'b0);
    tick(2);

    sweep(0);
    sweep(10);
    sweep(160);

    // host request on a trigger cycle, req held 3 clks
    push_mem(1'b0, 2, 0);
    push_mem(1'b1, 13'h0100, 8'h5A);
    push_ack(2, 1'b1, 0);
    ypos_in = 8'd0;
    xpos_in = 9'd4;
    host_addr = 13'h0100;
    host_wdata = 8'h5A;
`ifdef FB_HOST_READ_EN
    host_we = 1'b1;
`endif
    host_req = 1'b1;
    tick(3);
    host_req = 1'b0;
    tick(4);

    // out-of-range write is acked and dropped
    host_xfer(6400, 8'h33, 1'b1, 1, 0, 1'b0);
    tick(2);

    // reset during the write issue cycle aborts it; held req re-issues
    push_mem(1'b1, 13'h0300, 8'h77);
    push_ack(1, 1'b1, 0);
    host_addr = 13'h0300;
    host_wdata = 8'h77;
    host_req = 1'b1;
    tick(1);
    rst = 1'b1;
    @(negedge clk_8m);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_host_ack", host_ack, 0);
    tick(2);
    rst = 1'b0;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk_8m);
        if (host_ack) got = 1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL reissue_timeout: no host_ack after reset release");
      end
    end
    @(posedge clk_8m);
    #1;
    host_req = 1'b0;
    tick(3);

`ifdef FB_HOST_READ_EN
    host_xfer(13'h0100, 8'hA5, 1'b1, 1, 0, 1'b0);
    tick(2);
    host_xfer(6400, 8'h00, 1'b0, 2, 8'h00, 1'b0);
    tick(2);
    host_xfer(13'h0100, 8'h00, 1'b0, 2, 8'hA5, 1'b0);
    tick(3);
    chk("rdata_hold", host_rdata, 8'hA5);
`endif

    tick(5);
    chk("mem_events_left", mem_q.size(), 0);
    chk("acks_left", ack_q.size(), 0);
    chk("pix_left", pix_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
